// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and instruction-field constants for the
//                fetch/decode controller and its decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [3:0] {
        OPC_NOP  = 4'd0,
        OPC_ADD  = 4'd1,
        OPC_SUB  = 4'd2,
        OPC_AND  = 4'd3,
        OPC_OR   = 4'd4,
        OPC_MOV  = 4'd5,
        OPC_JMP  = 4'd6,
        OPC_BNZ  = 4'd7,
        OPC_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_MOV = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int TGT_MSB = 5;
    localparam int TGT_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/fetch_decode_ctrl_if.sv
// ============================================================================
//  Module      : fetch_decode_ctrl_if
//  Description : Instruction-memory, register-file and status signals of the
//                fetch/decode controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_decode_ctrl_if #(
    parameter int IM_ADDR_W  = 6,
    parameter int INSTR_W    = 16,
    parameter int REGF_WIDTH = 16
);
    logic                  start;
    logic [IM_ADDR_W-1:0]  im_addr;
    logic                  im_en;
    logic [INSTR_W-1:0]    im_rdata;
    logic [REGF_WIDTH-1:0] reg_out_op1;
    logic [1:0]            rs1;
    logic [1:0]            rs2;
    logic [1:0]            rd;
    logic [2:0]            alu_op;
    logic                  reg_we;
    logic                  halted;
    logic [15:0]           retired;

    modport master (
        input  start, im_rdata, reg_out_op1,
        output im_addr, im_en, rs1, rs2, rd, alu_op, reg_we, halted, retired
    );

    modport slave (
        output start, im_rdata, reg_out_op1,
        input  im_addr, im_en, rs1, rs2, rd, alu_op, reg_we, halted, retired
    );
endinterface

`default_nettype wire

// File: rtl/fetch_decode_ctrl_instr_decoder.sv
// ============================================================================
//  Module      : instr_decoder
//  Description : Combinational IR decode into register selects, ALU op and
//                instruction-class flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [1:0]  o_rs1,
    output logic [1:0]  o_rs2,
    output logic [1:0]  o_rd,
    output logic [5:0]  o_target,
    output alu_op_e     o_alu_op,
    output logic        o_is_wr,
    output logic        o_is_jmp,
    output logic        o_is_bnz,
    output logic        o_is_halt
);
    logic [3:0] w_opc;

    assign w_opc    = i_ir[OPC_MSB:OPC_LSB];
    assign o_rs1    = i_ir[RS1_MSB:RS1_LSB];
    assign o_rs2    = i_ir[RS2_MSB:RS2_LSB];
    assign o_rd     = i_ir[RD_MSB:RD_LSB];
    assign o_target = i_ir[TGT_MSB:TGT_LSB];

    // Reserved opcodes fall into the default arm and behave as NOP.
    always_comb begin
        o_alu_op  = ALU_ADD;
        o_is_wr   = 1'b0;
        o_is_jmp  = 1'b0;
        o_is_bnz  = 1'b0;
        o_is_halt = 1'b0;
        case (w_opc)
            OPC_ADD:  begin o_alu_op = ALU_ADD; o_is_wr = 1'b1; end
            OPC_SUB:  begin o_alu_op = ALU_SUB; o_is_wr = 1'b1; end
            OPC_AND:  begin o_alu_op = ALU_AND; o_is_wr = 1'b1; end
            OPC_OR:   begin o_alu_op = ALU_OR;  o_is_wr = 1'b1; end
            OPC_MOV:  begin o_alu_op = ALU_MOV; o_is_wr = 1'b1; end
            OPC_JMP:  o_is_jmp  = 1'b1;
            OPC_BNZ:  o_is_bnz  = 1'b1;
            OPC_HALT: o_is_halt = 1'b1;
            default:  ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fetch_decode_ctrl.sv
// ============================================================================
//  Module      : fetch_decode_ctrl
//  Description : Multi-cycle fetch/decode/execute controller owning the PC,
//                IR and retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int IM_ADDR_W  = 6,
    parameter int INSTR_W    = 16,
    parameter int REGF_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    fetch_decode_ctrl_if.master bus
);
    state_e               r_state;
    state_e               w_state_nxt;
    logic [IM_ADDR_W-1:0] r_pc;
    logic [IM_ADDR_W-1:0] w_pc_nxt;
    logic [IM_ADDR_W-1:0] w_pc_inc;
    logic [IM_ADDR_W-1:0] w_target;
    logic [INSTR_W-1:0]   r_ir;
    logic [15:0]          r_retired;

    logic                 w_ld_ir;
    logic                 w_exec;
    logic                 w_im_en;
    logic                 w_reg_we;
    logic                 w_halted;
    logic [2:0]           w_alu_op;
    logic                 w_op1_nz;

    logic [1:0]           w_rs1;
    logic [1:0]           w_rs2;
    logic [1:0]           w_rd;
    logic [5:0]           w_tgt_field;
    alu_op_e              w_dec_alu;
    logic                 w_is_wr;
    logic                 w_is_jmp;
    logic                 w_is_bnz;
    logic                 w_is_halt;

    instr_decoder u_dec (
        .i_ir      (r_ir[15:0]),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_rd      (w_rd),
        .o_target  (w_tgt_field),
        .o_alu_op  (w_dec_alu),
        .o_is_wr   (w_is_wr),
        .o_is_jmp  (w_is_jmp),
        .o_is_bnz  (w_is_bnz),
        .o_is_halt (w_is_halt)
    );

    // Size cast zero-extends the 6-bit target for wider PCs, truncates for narrower.
    assign w_target = IM_ADDR_W'(w_tgt_field);
    assign w_pc_inc = r_pc + IM_ADDR_W'(1);
    assign w_op1_nz = |bus.reg_out_op1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ld_ir) begin
                r_ir <= bus.im_rdata;
            end
            if (w_exec && (r_retired != 16'hFFFF)) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ld_ir     = 1'b0;
        w_exec      = 1'b0;
        w_im_en     = 1'b0;
        w_reg_we    = 1'b0;
        w_halted    = 1'b0;
        w_alu_op    = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_im_en     = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_ld_ir     = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_exec   = 1'b1;
                w_alu_op = w_dec_alu;
                w_reg_we = w_is_wr;
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH;
                    if (w_is_jmp || (w_is_bnz && w_op1_nz)) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.im_addr = r_pc;
    assign bus.im_en   = w_im_en;
    assign bus.rs1     = w_rs1;
    assign bus.rs2     = w_rs2;
    assign bus.rd      = w_rd;
    assign bus.alu_op  = w_alu_op;
    assign bus.reg_we  = w_reg_we;
    assign bus.halted  = w_halted;
    assign bus.retired = r_retired;

endmodule

`default_nettype wire
